// File: rtl/dmux8way16_buf_if.sv
// Producer/consumer bundle for dmux8way16_buf: one 16-bit word in, eight held words out with valid/ack.
// The master modport is the producer+consumers side; the slave modport is the distributor.
interface dmux8way16_buf_if;
   logic [15:0] inp;
   logic [2:0]  lines;
   logic        bcast;
   logic        inp_valid;
   logic        inp_ready;
   logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8;
   logic [7:0]  out_valid;
   logic [7:0]  out_ack;

   modport master (
      output inp, lines, bcast, inp_valid, out_ack,
      input  inp_ready, out1, out2, out3, out4, out5, out6, out7, out8, out_valid
   );

   modport slave (
      input  inp, lines, bcast, inp_valid, out_ack,
      output inp_ready, out1, out2, out3, out4, out5, out6, out7, out8, out_valid
   );
endinterface

// File: rtl/dmux8way16_buf.sv
// Registered 1-to-8 word distributor, 1-cycle latency; inp_ready drops while the target channel(s) are full.
// Define DMUX8WAY16_STATS_EN to add accept/stall counters with a synchronous stats_clr.
module dmux8way16_buf #(
   parameter logic [15:0] RESET_VAL    = 16'h0000,
   parameter bit          ALLOW_REFILL = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
`ifdef DMUX8WAY16_STATS_EN
   input  logic            stats_clr,
   output logic [15:0]     accept_cnt,
   output logic [15:0]     stall_cnt,
`endif
   dmux8way16_buf_if.slave bus
);

   logic [15:0] data_q [8];
   logic [7:0]  valid_q;
   logic [7:0]  free;
   logic [7:0]  wr;
   logic        rdy;
   logic        xfer;

   // A full channel counts as free when refill is allowed and its consumer acks this cycle.
   always_comb begin
      free = ~valid_q | (ALLOW_REFILL ? bus.out_ack : 8'h00);
      rdy  = bus.bcast ? (&free) : free[bus.lines];
      xfer = bus.inp_valid & rdy;
      wr   = 8'h00;
      if (xfer) begin
         wr = bus.bcast ? 8'hFF : (8'h01 << bus.lines);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            data_q[k] <= RESET_VAL;
         end
         valid_q <= 8'h00;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (wr[k]) begin
               data_q[k]  <= bus.inp;
               valid_q[k] <= 1'b1;
            end else if (bus.out_ack[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.inp_ready = rdy;
   assign bus.out_valid = valid_q;
   assign bus.out1      = data_q[0];
   assign bus.out2      = data_q[1];
   assign bus.out3      = data_q[2];
   assign bus.out4      = data_q[3];
   assign bus.out5      = data_q[4];
   assign bus.out6      = data_q[5];
   assign bus.out7      = data_q[6];
   assign bus.out8      = data_q[7];

`ifdef DMUX8WAY16_STATS_EN
   // A broadcast is one transfer; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accept_cnt <= 16'h0000;
         stall_cnt  <= 16'h0000;
      end else if (stats_clr) begin
         accept_cnt <= 16'h0000;
         stall_cnt  <= 16'h0000;
      end else begin
         if (xfer) begin
            accept_cnt <= accept_cnt + 16'd1;
         end
         if (bus.inp_valid && !rdy) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Bench for dmux8way16_buf: two instances (refill off / on) share stimulus, each tracked by its own model.
module tb_dmux8way16_buf;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] inp = '0;
   logic [2:0]  lines = '0;
   logic        bcast = 1'b0;
   logic        vld = 1'b0;
   logic [7:0]  ack = '0;
   logic        sclr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   dmux8way16_buf_if b0 ();
   dmux8way16_buf_if b1 ();

   assign b0.inp = inp;   assign b1.inp = inp;
   assign b0.lines = lines; assign b1.lines = lines;
   assign b0.bcast = bcast; assign b1.bcast = bcast;
   assign b0.inp_valid = vld; assign b1.inp_valid = vld;
   assign b0.out_ack = ack; assign b1.out_ack = ack;

   logic [15:0] acc_o [2];
   logic [15:0] stall_o [2];

`ifdef DMUX8WAY16_STATS_EN
   dmux8way16_buf #(.RESET_VAL(16'h0000), .ALLOW_REFILL(1'b0)) dut0 (
      .clk(clk), .rst(rst), .stats_clr(sclr), .accept_cnt(acc_o[0]), .stall_cnt(stall_o[0]), .bus(b0.slave));
   dmux8way16_buf #(.RESET_VAL(16'h0000), .ALLOW_REFILL(1'b1)) dut1 (
      .clk(clk), .rst(rst), .stats_clr(sclr), .accept_cnt(acc_o[1]), .stall_cnt(stall_o[1]), .bus(b1.slave));
`else
   assign acc_o[0] = '0;   assign acc_o[1] = '0;
   assign stall_o[0] = '0; assign stall_o[1] = '0;
   dmux8way16_buf #(.RESET_VAL(16'h0000), .ALLOW_REFILL(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(b0.slave));
   dmux8way16_buf #(.RESET_VAL(16'h0000), .ALLOW_REFILL(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1.slave));
`endif

   always #5 clk = ~clk;

   logic [15:0] od [2][8];
   logic [7:0]  ov [2];
   logic        ordy [2];
   assign od[0][0] = b0.out1; assign od[0][1] = b0.out2; assign od[0][2] = b0.out3; assign od[0][3] = b0.out4;
   assign od[0][4] = b0.out5; assign od[0][5] = b0.out6; assign od[0][6] = b0.out7; assign od[0][7] = b0.out8;
   assign od[1][0] = b1.out1; assign od[1][1] = b1.out2; assign od[1][2] = b1.out3; assign od[1][3] = b1.out4;
   assign od[1][4] = b1.out5; assign od[1][5] = b1.out6; assign od[1][6] = b1.out7; assign od[1][7] = b1.out8;
   assign ov[0] = b0.out_valid; assign ov[1] = b1.out_valid;
   assign ordy[0] = b0.inp_ready; assign ordy[1] = b1.inp_ready;

   // Reference model: per instance, 8 held words, 8 valid bits, two counters.
   logic [15:0] md [2][8];
   logic [7:0]  mv [2];
   logic [15:0] macc [2];
   logic [15:0] mstall [2];

   function automatic logic model_ready(int i);
      logic [7:0] f;
      for (int k = 0; k < 8; k++) f[k] = !mv[i][k] || ((i == 1) && ack[k]);
      return bcast ? (&f) : f[lines];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 8; k++) md[i][k] = 16'h0000;
         mv[i] = 8'h00; macc[i] = 16'h0000; mstall[i] = 16'h0000;
      end
   endtask

   // Advance one clock edge, moving the model with it.
   task automatic tick();
      logic [15:0] nd [2][8];
      logic [7:0]  nv [2];
      logic [15:0] na [2];
      logic [15:0] ns [2];
      logic r;
      for (int i = 0; i < 2; i++) begin
         r = model_ready(i);
         nv[i] = mv[i]; na[i] = macc[i]; ns[i] = mstall[i];
         for (int k = 0; k < 8; k++) begin
            nd[i][k] = md[i][k];
            if (vld && r && (bcast || lines == 3'(k))) begin
               nd[i][k] = inp; nv[i][k] = 1'b1;
            end else if (ack[k]) begin
               nv[i][k] = 1'b0;
            end
         end
         if (sclr) begin
            na[i] = 16'h0000; ns[i] = 16'h0000;
         end else begin
            if (vld && r) na[i] = na[i] + 16'd1;
            if (vld && !r) ns[i] = ns[i] + 16'd1;
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 8; k++) md[i][k] = nd[i][k];
         mv[i] = nv[i]; macc[i] = na[i]; mstall[i] = ns[i];
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      inp = 16'h1357; bcast = 1'b1; vld = 1'b1; ack = 8'h00;
      #1;
      tick();
      vld = 1'b0; bcast = 1'b0;
      #2 rst = 1'b1; model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (od[i][k] !== 16'h0000) begin
               n_bad++; $display("FAIL reset_data inst=%0d ch=%0d got=%h exp=0000", i, k + 1, od[i][k]);
            end
         end
         n_cmp++;
         if (ov[i] !== 8'h00) begin
            n_bad++; $display("FAIL reset_valid inst=%0d got=%h exp=00", i, ov[i]);
         end
      end
      vld = 1'b1;
      for (int l = 0; l < 8; l++) begin
         lines = 3'(l);
         #1;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ordy[i] !== 1'b1) begin
               n_bad++; $display("FAIL reset_ready inst=%0d lines=%0d got=%b exp=1", i, l, ordy[i]);
            end
         end
      end
      vld = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_write();
      inp = 16'hABCD; lines = 3'd5; vld = 1'b1; ack = 8'h00; bcast = 1'b0;
      #1;
      tick();
      vld = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (ov[i] !== 8'h20 || od[i][5] !== 16'hABCD) begin
            n_bad++; $display("FAIL single_write inst=%0d got v=%h d=%h exp v=20 d=abcd", i, ov[i], od[i][5]);
         end
         for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (od[i][k] !== md[i][k]) begin
               n_bad++; $display("FAIL single_data inst=%0d ch=%0d got=%h exp=%h", i, k + 1, od[i][k], md[i][k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      inp = 16'h1234; lines = 3'd5; vld = 1'b1; ack = 8'h00;
      #1;
      n_cmp++;
      if (ordy[0] !== 1'b0) begin
         n_bad++; $display("FAIL bp_blocked got=%b exp=0", ordy[0]);
      end
      tick();
      n_cmp++;
      if (od[0][5] !== 16'hABCD) begin
         n_bad++; $display("FAIL bp_hold got=%h exp=abcd", od[0][5]);
      end
      ack = 8'h20;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (ordy[i] !== model_ready(i)) begin
            n_bad++; $display("FAIL bp_ack_ready inst=%0d got=%b exp=%b", i, ordy[i], model_ready(i));
         end
      end
      tick();
      ack = 8'h00;
      n_cmp++;
      if (ov[0][5] !== 1'b0) begin
         n_bad++; $display("FAIL bp_cleared got=%b exp=0", ov[0][5]);
      end
      #1;
      n_cmp++;
      if (ordy[0] !== 1'b1) begin
         n_bad++; $display("FAIL bp_reopen got=%b exp=1", ordy[0]);
      end
      tick();
      vld = 1'b0;
      n_cmp++;
      if (od[0][5] !== 16'h1234 || ov[0][5] !== 1'b1) begin
         n_bad++; $display("FAIL bp_land got d=%h v=%b exp d=1234 v=1", od[0][5], ov[0][5]);
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (ov[i] !== mv[i] || od[i][5] !== md[i][5]) begin
            n_bad++; $display("FAIL bp_model inst=%0d got v=%h d=%h exp v=%h d=%h", i, ov[i], od[i][5], mv[i], md[i][5]);
         end
      end
   endtask

   task automatic test_ack_refill();
      inp = 16'h1111; lines = 3'd2; vld = 1'b1; ack = 8'h00;
      #1;
      tick();
      inp = 16'h5A5A; ack = 8'h04;
      #1;
      n_cmp++;
      if (ordy[1] !== 1'b1) begin
         n_bad++; $display("FAIL refill_ready got=%b exp=1", ordy[1]);
      end
      n_cmp++;
      if (ordy[0] !== 1'b0) begin
         n_bad++; $display("FAIL norefill_ready got=%b exp=0", ordy[0]);
      end
      tick();
      vld = 1'b0; ack = 8'h00;
      n_cmp++;
      if (od[1][2] !== 16'h5A5A || ov[1][2] !== 1'b1) begin
         n_bad++; $display("FAIL refill_land got d=%h v=%b exp d=5a5a v=1", od[1][2], ov[1][2]);
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (ov[i] !== mv[i] || od[i][2] !== md[i][2]) begin
            n_bad++; $display("FAIL refill_model inst=%0d got v=%h d=%h exp v=%h d=%h", i, ov[i], od[i][2], mv[i], md[i][2]);
         end
      end
   endtask

   task automatic test_broadcast();
      vld = 1'b0; ack = 8'hFF;
      tick();
      ack = 8'h00; inp = 16'h7777; lines = 3'd7; vld = 1'b1;
      #1;
      tick();
      bcast = 1'b1; inp = 16'hFFFF;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (ordy[i] !== 1'b0) begin
            n_bad++; $display("FAIL bcast_blocked inst=%0d got=%b exp=0", i, ordy[i]);
         end
      end
      vld = 1'b0; ack = 8'h80;
      tick();
      ack = 8'h00; vld = 1'b1;
      #1;
      tick();
      vld = 1'b0; bcast = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (ov[i] !== 8'hFF) begin
            n_bad++; $display("FAIL bcast_valid inst=%0d got=%h exp=ff", i, ov[i]);
         end
         for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (od[i][k] !== 16'hFFFF) begin
               n_bad++; $display("FAIL bcast_data inst=%0d ch=%0d got=%h exp=ffff", i, k + 1, od[i][k]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         inp   = 16'($urandom);
         lines = 3'($urandom_range(0, 7));
         bcast = ($urandom_range(0, 9) == 0);
         vld   = ($urandom_range(0, 3) != 0);
         ack   = 8'($urandom) & 8'($urandom);
         #1;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ordy[i] !== model_ready(i)) begin
               n_bad++; $display("FAIL rand_ready cyc=%0d inst=%0d got=%b exp=%b", c, i, ordy[i], model_ready(i));
            end
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ov[i] !== mv[i]) begin
               n_bad++; $display("FAIL rand_valid cyc=%0d inst=%0d got=%h exp=%h", c, i, ov[i], mv[i]);
            end
            for (int k = 0; k < 8; k++) begin
               n_cmp++;
               if (od[i][k] !== md[i][k]) begin
                  n_bad++; $display("FAIL rand_data cyc=%0d inst=%0d ch=%0d got=%h exp=%h", c, i, k + 1, od[i][k], md[i][k]);
               end
            end
         end
      end
      vld = 1'b0; bcast = 1'b0; ack = 8'h00;
   endtask

`ifdef DMUX8WAY16_STATS_EN
   task automatic test_stats();
      int guard;
      rst = 1'b1; model_reset();
      #1 rst = 1'b0;
      ack = 8'h00; bcast = 1'b0; vld = 1'b1;
      for (int l = 0; l < 3; l++) begin
         lines = 3'(l);
         tick();
      end
      lines = 3'd0;
      tick();
      tick();
      vld = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (acc_o[i] !== 16'd3 || stall_o[i] !== 16'd2) begin
            n_bad++; $display("FAIL stats_count inst=%0d got acc=%0d stall=%0d exp acc=3 stall=2", i, acc_o[i], stall_o[i]);
         end
      end
      bcast = 1'b1; vld = 1'b1; ack = 8'hFF;
      guard = 0;
      while (macc[1] != 16'hFFFF && guard < 70000) begin
         tick();
         guard++;
      end
      n_cmp++;
      if (acc_o[1] !== 16'hFFFF) begin
         n_bad++; $display("FAIL stats_preload got=%h exp=ffff", acc_o[1]);
      end
      tick();
      n_cmp++;
      if (acc_o[1] !== 16'h0000) begin
         n_bad++; $display("FAIL stats_wrap got=%h exp=0000", acc_o[1]);
      end
      sclr = 1'b1;
      tick();
      sclr = 1'b0; vld = 1'b0; bcast = 1'b0; ack = 8'h00;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (acc_o[i] !== 16'h0000 || stall_o[i] !== 16'h0000) begin
            n_bad++; $display("FAIL stats_clr inst=%0d got acc=%h stall=%h exp 0000", i, acc_o[i], stall_o[i]);
         end
         n_cmp++;
         if (acc_o[i] !== macc[i] || stall_o[i] !== mstall[i]) begin
            n_bad++; $display("FAIL stats_model inst=%0d got acc=%h stall=%h exp acc=%h stall=%h", i, acc_o[i], stall_o[i], macc[i], mstall[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_backpressure();
      test_ack_refill();
      test_broadcast();
      test_random();
`ifdef DMUX8WAY16_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dmux8way16_buf.md
Name: dmux8way16_buf

Overview:
- Registered 1-to-8 distributor for 16-bit words; the write-side counterpart of the 8-way 16-bit selector.
- Each accepted input word goes to one of 8 single-entry holding registers, chosen by `lines`.
- Each channel exposes its word with a valid flag; the downstream consumer clears the flag with an ack.
- Sits between a single producer (ALU/bus result) and up to 8 consumers (register bank, I/O ports).

Parameters:
- RESET_VAL, 16'h0000, value loaded into out1..out8 on reset.
- ALLOW_REFILL, 1, when 1 a full channel whose ack is high in the same cycle accepts a new word (ready stays high); when 0 the channel must be empty.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- inp  input  16  word to distribute.
- lines  input  3  destination channel select; 0 -> out1 ... 7 -> out8.
- bcast  input  1  broadcast: write inp to all 8 channels; `lines` is ignored.
- inp_valid  input  1  producer offers inp this cycle.
- inp_ready  output  1  block accepts inp this cycle (combinational).
- out1..out8  output  16 each  channel holding registers.
- out_valid  output  8  bit k-1 set while outk holds an unconsumed word.
- out_ack  input  8  bit k-1 consumes outk; clears its valid at the next edge.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out1..out8 = RESET_VAL; out_valid = 8'h00.
  - Optional counters = 0.
  - inp_ready follows combinationally from the cleared state.
- free[k] = !out_valid[k] | (ALLOW_REFILL & out_ack[k]).
- inp_ready:
  - bcast=0: inp_ready = free[lines].
  - bcast=1: inp_ready = AND of free[0..7].
- Transfer = inp_valid & inp_ready, sampled at the rising edge. Latency 1: the word appears on outk with out_valid[k-1]=1 in the cycle after the transfer edge.
- Per channel k, next state, highest priority first:
  - Written this edge: outk <= inp, valid <= 1. A simultaneous ack on the same channel loses; the new word stays valid.
  - Else out_ack[k-1]=1: valid <= 0, data unchanged.
  - Else: hold.
- Data registers never change except on write or reset. Unselected channels are never disturbed.
- Ack on an empty channel has no effect.
- inp_valid=0: no writes; acks still processed.
- `lines` and `bcast` are only meaningful while inp_valid=1. inp_ready may toggle freely with them.
- No internal state machine beyond the 8 valid flags. Channels are independent.

Optional Feature:
- Macro: DMUX8WAY16_STATS_EN.
- Defined:
  - Adds output `accept_cnt` (16 bits): counts transfers; a broadcast counts as 1.
  - Adds output `stall_cnt` (16 bits): counts cycles with inp_valid=1 and inp_ready=0.
  - Both counters wrap FFFF -> 0000 and reset to 0.
  - Adds input `stats_clr` (synchronous): zeroes both counters at the next edge, overriding any increment that cycle.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-cycle with no clock edge.
  - Required response: all outk = 0000 and out_valid = 00 immediately; inp_ready = 1 for any lines.
- Single routed write:
  - Stimulus: inp=ABCD, lines=5, inp_valid=1 for one cycle.
  - Required response: next cycle out6 = ABCD and out_valid = 8'h20; all other outk = 0000.
- Backpressure:
  - Stimulus: channel 6 full, ALLOW_REFILL=0, inp=1234 to lines=5.
  - Required response: inp_ready = 0 and out6 stays ABCD.
  - Stimulus: pulse out_ack[5].
  - Required response: out_valid[5] = 0 next cycle, then inp_ready = 1 and 1234 lands in out6.
- Ack+refill:
  - Stimulus: ALLOW_REFILL=1, channel 3 full, out_ack[2]=1 with inp=5A5A, lines=2 in the same cycle.
  - Required response: inp_ready = 1; next cycle out3 = 5A5A and out_valid[2] = 1.
- Broadcast:
  - Stimulus: channel 8 full, bcast=1, inp=FFFF.
  - Required response: inp_ready = 0.
  - Stimulus: ack channel 8, then repeat the broadcast.
  - Required response: all outk = FFFF and out_valid = FF.
- Stats (macro defined):
  - Stimulus: 3 transfers and 2 stall cycles.
  - Required response: accept_cnt = 3 and stall_cnt = 2.
  - Stimulus: preload counters to FFFF, then one transfer.
  - Required response: accept_cnt = 0000.
  - Stimulus: pulse stats_clr.
  - Required response: both counters = 0 next cycle.
